// File: rtl/tmds_lock_sequencer.sv
// TMDS PLL reset/lock sequencer: pulses PLL reset, waits for a stable lock, then releases the TMDS pipeline reset.
// Optional lock-loss debug counter enabled by defining TMDS_LOCK_LOSS_CNT_EN.
module tmds_lock_sequencer #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 65535,
  parameter int STABLE_CYCLES  = 1024
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       lock,
  output logic       pll_reset,
  output logic       rst_out,
  output logic       ready,
  output logic [7:0] lock_loss_cnt
);

  localparam int MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_P = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
  localparam int CNT_W = (MAX_P > 1) ? $clog2(MAX_P) : 1;

  localparam logic [CNT_W-1:0] PLL_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             lock_meta, lock_s;

  // lock comes straight from the PLL and is asynchronous to clkin
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= lock;
      lock_s    <= lock_meta;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RESET_PLL: if (cnt == PLL_LAST) state_next = WAIT_LOCK;
      WAIT_LOCK: begin
        if (lock_s)                    state_next = STABLE;
        else if (cnt == TIMEOUT_LAST)  state_next = RESET_PLL;
      end
      STABLE: begin
        if (!lock_s)                   state_next = WAIT_LOCK;
        else if (cnt == STABLE_LAST)   state_next = RUN;
      end
      RUN:     if (!lock_s) state_next = RESET_PLL;
      default: state_next = RESET_PLL;
    endcase
    cnt_next = (state_next != state) ? '0 : cnt + 1'b1;
  end

  // Outputs are decoded from the next state so they move on the same edge as the state
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state     <= RESET_PLL;
      cnt       <= '0;
      pll_reset <= 1'b1;
      rst_out   <= 1'b1;
      ready     <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      pll_reset <= (state_next == RESET_PLL);
      rst_out   <= (state_next != RUN);
      ready     <= (state_next == RUN);
    end
  end

`ifdef TMDS_LOCK_LOSS_CNT_EN
  logic lock_loss;
  logic [7:0] loss_cnt;

  assign lock_loss = (state == RUN) && !lock_s;

  // Saturating debug count of lock losses seen while running
  always_ff @(posedge clkin or posedge reset) begin
    if (reset)
      loss_cnt <= 8'd0;
    else if (lock_loss && (loss_cnt != 8'hFF))
      loss_cnt <= loss_cnt + 8'd1;
  end

  assign lock_loss_cnt = loss_cnt;
`else
  assign lock_loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_tmds_lock_sequencer.sv
// Scoreboard bench for tmds_lock_sequencer: expected output values are queued against absolute clock-edge indices.
module tb_tmds_lock_sequencer;

  logic       clkin = 1'b0;
  logic       reset;
  logic       lock;
  logic       pll_reset;
  logic       rst_out;
  logic       ready;
  logic [7:0] lock_loss_cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  localparam int F_PLL = 0, F_RST = 1, F_RDY = 2, F_CNT = 3;

  typedef struct {
    int    at;
    int    field;
    int    val;
    string tag;
  } exp_t;

  exp_t sb[$];

  tmds_lock_sequencer #(
    .PLL_RST_CYCLES(4),
    .LOCK_TIMEOUT  (32),
    .STABLE_CYCLES (8)
  ) dut (
    .clkin        (clkin),
    .reset        (reset),
    .lock         (lock),
    .pll_reset    (pll_reset),
    .rst_out      (rst_out),
    .ready        (ready),
    .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 clkin = ~clkin;

  always @(posedge clkin) cyc <= cyc + 1;

  task automatic check_output(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int observe(input int field);
    case (field)
      F_PLL:   return int'(pll_reset);
      F_RST:   return int'(rst_out);
      F_RDY:   return int'(ready);
      default: return int'(lock_loss_cnt);
    endcase
  endfunction

  function automatic int exp_cnt(input int events);
`ifdef TMDS_LOCK_LOSS_CNT_EN
    return (events > 255) ? 255 : events;
`else
    return (events >= 0) ? 0 : 0;
`endif
  endfunction

  task automatic push_exp(input int at, input int field, input int val, input string tag);
    exp_t e;
    e.at = at; e.field = field; e.val = val; e.tag = tag;
    sb.push_back(e);
  endtask

  // Outputs are compared mid-cycle, well away from the rising edge
  always @(negedge clkin) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      check_output(e.tag, observe(e.field), e.val);
    end
  end

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clkin);
    #1;
  endtask

  task automatic drain_scoreboard();
    int budget;
    budget = 200;
    while (sb.size() > 0 && budget > 0) begin
      @(posedge clkin);
      budget--;
    end
    if (sb.size() != 0) check_output("sb_drain", sb.size(), 0);
    sb.delete();
  endtask

  task automatic apply_stimulus();
    int n, m, r, events;

    // Reset release with lock low: 4-cycle PLL pulse, 32-cycle wait, pulse again
    reset = 1'b1;
    lock  = 1'b0;
    wait_edges(3);
    check_output("rst_pll_reset", int'(pll_reset), 1);
    check_output("rst_rst_out", int'(rst_out), 1);
    check_output("rst_ready", int'(ready), 0);
    check_output("rst_cnt", int'(lock_loss_cnt), 0);
    reset = 1'b0;
    n = cyc;
    push_exp(n + 1,  F_PLL, 1, "pulse_first");
    push_exp(n + 3,  F_PLL, 1, "pulse_last");
    push_exp(n + 4,  F_PLL, 0, "pulse_end");
    push_exp(n + 20, F_RST, 1, "wait_rst_out");
    push_exp(n + 20, F_RDY, 0, "wait_ready");
    push_exp(n + 35, F_PLL, 0, "timeout_last_low");
    push_exp(n + 36, F_PLL, 1, "timeout_repulse");
    push_exp(n + 38, F_RST, 1, "repulse_rst_out");
    push_exp(n + 39, F_PLL, 1, "repulse_last");
    push_exp(n + 40, F_PLL, 0, "repulse_end");
    wait_edges(41);

    // Lock found, then a 2-cycle drop during STABLE restarts the window
    lock = 1'b1;
    wait_edges(4);
    lock = 1'b0;
    wait_edges(2);
    lock = 1'b1;
    r = cyc;
    push_exp(r + 5,  F_RST, 1, "glitch_no_early_run");
    push_exp(r + 10, F_RST, 1, "glitch_run_minus1");
    push_exp(r + 11, F_RST, 0, "glitch_run_rst_out");
    push_exp(r + 11, F_RDY, 1, "glitch_run_ready");
    push_exp(r + 11, F_CNT, exp_cnt(0), "glitch_cnt");
    wait_edges(11);

    // Loss in RUN for 3 cycles, then relock back to RUN
    m = cyc;
    lock = 1'b0;
    push_exp(m + 2,  F_RST, 0, "loss_rst_before");
    push_exp(m + 2,  F_PLL, 0, "loss_pll_before");
    push_exp(m + 2,  F_CNT, exp_cnt(0), "loss_cnt_before");
    push_exp(m + 3,  F_RST, 1, "loss_rst_out");
    push_exp(m + 3,  F_PLL, 1, "loss_pll_reset");
    push_exp(m + 3,  F_RDY, 0, "loss_ready");
    push_exp(m + 3,  F_CNT, exp_cnt(1), "loss_cnt");
    push_exp(m + 15, F_RDY, 0, "relock_minus1");
    push_exp(m + 16, F_RDY, 1, "relock_ready");
    wait_edges(3);
    lock = 1'b1;
    wait_edges(13);

    // Repeated losses from RUN until the counter saturates
    events = 1;
    for (int k = 0; k < 259; k++) begin
      m = cyc;
      events++;
      lock = 1'b0;
      push_exp(m + 3,  F_CNT, exp_cnt(events), "sat_cnt");
      push_exp(m + 16, F_RDY, 1, "sat_relock");
      wait_edges(3);
      lock = 1'b1;
      wait_edges(13);
    end
    drain_scoreboard();
    check_output("sat_final_cnt", int'(lock_loss_cnt), exp_cnt(260));
    check_output("sat_final_ready", int'(ready), 1);

    // Asynchronous reset while running, sampled before any clock edge
    @(posedge clkin);
    #2 reset = 1'b1;
    #1;
    check_output("areset_pll_reset", int'(pll_reset), 1);
    check_output("areset_rst_out", int'(rst_out), 1);
    check_output("areset_ready", int'(ready), 0);
    check_output("areset_cnt", int'(lock_loss_cnt), 0);
    wait_edges(3);

    // Clean acquisition after reset: RUN ten edges after lock is first sampled
    lock  = 1'b0;
    reset = 1'b0;
    n = cyc;
    push_exp(n + 4, F_PLL, 0, "clean_pulse_end");
    wait_edges(6);
    lock = 1'b1;
    m = cyc;
    push_exp(m + 10, F_RST, 1, "clean_run_minus1");
    push_exp(m + 10, F_RDY, 0, "clean_ready_minus1");
    push_exp(m + 11, F_RST, 0, "clean_run_rst_out");
    push_exp(m + 11, F_RDY, 1, "clean_run_ready");
    push_exp(m + 11, F_PLL, 0, "clean_run_pll");
    push_exp(m + 11, F_CNT, 0, "clean_run_cnt");
    wait_edges(12);
    drain_scoreboard();
  endtask

  initial begin
    apply_stimulus();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
